// File: rtl/barrel_rotl_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | barrel_rotl_seq_pkg                                                      |
// | Shared log2 helper and FSM state encodings for the sequential rotator.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package barrel_rotl_seq_pkg;

    // Same definition as the right-rotator: ceil(log2(n)) for n >= 1.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/barrel_rotl_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | barrel_rotl_stage                                                        |
// | One log2 stage: rotates left by 2^k when en is set, else passes through. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module barrel_rotl_stage
    import barrel_rotl_seq_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SEL_W     = log2(DATA_SIZE)
) (
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic [SEL_W-1:0]     k,
    input  logic                 en,
    output logic [DATA_SIZE-1:0] data_out
);

    logic [SEL_W-1:0]       amt;
    logic [2*DATA_SIZE-1:0] dbl;

    // Shifting a doubled word left and keeping the upper half is a rotation.
    always_comb begin
        amt      = SEL_W'(1) << k;
        dbl      = {data_in, data_in} << amt;
        data_out = en ? dbl[2*DATA_SIZE-1 -: DATA_SIZE] : data_in;
    end

endmodule
`default_nettype wire

// File: rtl/barrel_rotl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | barrel_rotl_seq                                                          |
// | Sequential left-rotator, one log2 stage per cycle, valid/ready on both   |
// | sides. Inverse of the right-rotating barrel shifter.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module barrel_rotl_seq
    import barrel_rotl_seq_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SEL_W     = log2(DATA_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 busy
);

    localparam logic [SEL_W-1:0] K_LAST = SEL_W'(SEL_W - 1);

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   data_q, data_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SEL_W-1:0]       k_q, k_d;
    logic [DATA_SIZE-1:0]   data_out_q, data_out_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0]   stage_out;

    barrel_rotl_stage #(
        .DATA_SIZE (DATA_SIZE),
        .SEL_W     (SEL_W)
    ) u_stage (
        .data_in  (data_q),
        .k        (k_q),
        .en       (sel_q[k_q]),
        .data_out (stage_out)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        sel_d       = sel_q;
        k_d         = k_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    sel_d   = sel;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = stage_out;
                k_d    = k_q + SEL_W'(1);
                // Final stage result goes straight to the output register.
                if (k_q == K_LAST) begin
                    data_out_d  = stage_out;
                    out_valid_d = 1'b1;
                    k_d         = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            sel_q       <= '0;
            k_q         <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            k_q         <= k_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_rotl_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_barrel_rotl_seq                                                       |
// | Self-checking bench: directed cases, full sweep, random backpressure.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_barrel_rotl_seq;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] sel;
    logic [W-1:0]  data_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  data_out;
    logic          busy;

    int n_checks;
    int n_errors;

    barrel_rotl_seq #(.DATA_SIZE(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of the input lands at bit (i+s) mod W.
    function automatic logic [W-1:0] rotl_model(input logic [W-1:0] x, input int s);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[(i + s) % W] = x[i];
        return r;
    endfunction

    function automatic logic [W-1:0] rotr_model(input logic [W-1:0] x, input int s);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[(i + s) % W];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; hold = cycles out_ready stays low once DONE is reached.
    task automatic run_txn(input logic [W-1:0] d, input int s, input int hold, input bit full);
        logic [W-1:0] exp;
        int lat;
        exp       = rotl_model(d, s);
        in_valid  = 1'b1;
        data_in   = d;
        sel       = SW'(s);
        out_ready = (hold == 0);
        tick();
        lat = 0;
        // Junk offered during RUN must be ignored and never resampled.
        while (!out_valid && lat < 20) begin
            in_valid = 1'b1;
            data_in  = W'($urandom);
            sel      = SW'($urandom);
            if (full && lat == 0) begin
                chk("run_in_ready", 32'(in_ready), 32'd0);
                chk("run_busy", 32'(busy), 32'd1);
            end
            tick();
            lat++;
        end
        chk("latency", lat, SW);
        chk("data_out", 32'(data_out), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            if (h == hold - 1) in_valid = 1'b0;
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(data_out), 32'(exp));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        if (full) begin
            chk("pulse_end", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = '0;
        data_in   = '0;

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        run_txn(8'hB4, 3, 0, 1'b1);
        chk("dir_B4_3", 32'(data_out), 32'h A5);
        run_txn(8'h5A, 0, 0, 1'b1);
        chk("dir_5A_0", 32'(data_out), 32'h5A);
        run_txn(8'h01, 7, 0, 1'b1);
        chk("dir_01_7", 32'(data_out), 32'h80);
        run_txn(rotr_model(8'hB4, 3), 3, 0, 1'b1);
        chk("round_trip", 32'(data_out), 32'hB4);

        run_txn(8'hC3, 5, 5, 1'b1);

        // Reset during the second RUN cycle aborts the in-flight word.
        in_valid  = 1'b1;
        data_in   = 8'h3C;
        sel       = 3'd6;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data_out", 32'(data_out), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_txn(8'h3C, 6, 0, 1'b1);

        for (int v = 0; v < 256; v++) begin
            for (int s = 0; s < 8; s++) begin
                run_txn(W'(v), s, 0, 1'b0);
            end
        end

        for (int i = 0; i < 40; i++) begin
            run_txn(W'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 5)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
